// File: rtl/apb_i2c_fifo_if.sv
// apb_i2c_fifo_if: push/pop bundle between the APB bridge or I2C core and
// the FIFO.
interface apb_i2c_fifo_if #(
  parameter int DWIDTH = 32,
  parameter int DEPTH  = 16
);
  localparam int AW = $clog2(DEPTH);

  logic              CLR;
  logic              WR_EN;
  logic [DWIDTH-1:0] WDATA;
  logic              RD_EN;
  logic [DWIDTH-1:0] RDATA;
  logic              FULL;
  logic              EMPTY;
  logic [AW:0]       COUNT;
  logic              OVERFLOW;
  logic              UNDERFLOW;

  modport master (
    output CLR, WR_EN, WDATA, RD_EN,
    input  RDATA, FULL, EMPTY, COUNT,
    input  OVERFLOW, UNDERFLOW
  );

  modport slave (
    input  CLR, WR_EN, WDATA, RD_EN,
    output RDATA, FULL, EMPTY, COUNT,
    output OVERFLOW, UNDERFLOW
  );
endinterface

// File: rtl/apb_i2c_fifo.sv
// apb_i2c_fifo: single-clock TX/RX FIFO for the APB I2C bridge.
// Define APB_I2C_FIFO_FWFT_EN for first-word-fall-through RDATA.
module apb_i2c_fifo #(
  parameter int DWIDTH = 32,
  parameter int DEPTH  = 16,
  localparam int AW    = $clog2(DEPTH)
) (
  input logic          PCLK,
  input logic          PRESET,
  apb_i2c_fifo_if.slave bus
);

  logic [DWIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [AW:0]       count;
  logic              full;
  logic              empty;
  logic              push_ok;
  logic              pop_ok;
  logic              ovf;
  logic              udf;

  assign full  = count == (AW+1)'(DEPTH);
  assign empty = count == '0;

  // CLR wins over both requests, so nothing moves on a flush edge
  assign push_ok = bus.WR_EN & ~full  & ~bus.CLR;
  assign pop_ok  = bus.RD_EN & ~empty & ~bus.CLR;

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      ovf    <= 1'b0;
      udf    <= 1'b0;
    end else if (bus.CLR) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      ovf    <= 1'b0;
      udf    <= 1'b0;
    end else begin
      if (push_ok)
        wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)
        rd_ptr <= rd_ptr + 1'b1;
      unique case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (bus.WR_EN & full)
        ovf <= 1'b1;
      if (bus.RD_EN & empty)
        udf <= 1'b1;
    end
  end

  always_ff @(posedge PCLK) begin
    if (push_ok)
      mem[wr_ptr] <= bus.WDATA;
  end

`ifdef APB_I2C_FIFO_FWFT_EN
  assign bus.RDATA = empty ? '0 : mem[rd_ptr];
`else
  logic [DWIDTH-1:0] rdata;

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET)
      rdata <= '0;
    else if (pop_ok)
      rdata <= mem[rd_ptr];
  end

  assign bus.RDATA = rdata;
`endif

  assign bus.FULL      = full;
  assign bus.EMPTY     = empty;
  assign bus.COUNT     = count;
  assign bus.OVERFLOW  = ovf;
  assign bus.UNDERFLOW = udf;

endmodule

// File: tb/tb_apb_i2c_fifo.sv
// tb_apb_i2c_fifo: directed bench with a pop scoreboard for apb_i2c_fifo.
// Expected pop data is queued at stimulus time and checked by a monitor.
module tb_apb_i2c_fifo;

  logic PCLK = 1'b0;
  logic PRESET;

  always #5 PCLK = ~PCLK;

  apb_i2c_fifo_if #(.DWIDTH(32), .DEPTH(16)) bus ();

  apb_i2c_fifo #(.DWIDTH(32), .DEPTH(16)) dut (
    .PCLK   (PCLK),
    .PRESET (PRESET),
    .bus    (bus)
  );

  int vecs = 0;
  int errs = 0;

  logic [31:0] mdl [$];
  logic [31:0] exp_q [$];

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    vecs++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h want %0h", nm, got, exp);
    end
  endtask

  // Monitor: whenever the DUT accepts a pop, compare against the queue
  always @(posedge PCLK) begin
    if (!PRESET && !bus.CLR && bus.RD_EN && !bus.EMPTY) begin
`ifndef APB_I2C_FIFO_FWFT_EN
      #1;
`endif
      vecs++;
      if (exp_q.size() == 0) begin
        errs++;
        $display("FAIL pop_unexpected: got %0h want none", bus.RDATA);
      end else begin
        logic [31:0] e;
        e = exp_q.pop_front();
        if (bus.RDATA !== e) begin
          errs++;
          $display("FAIL pop_data: got %0h want %0h", bus.RDATA, e);
        end
      end
    end
  end

  task automatic step(input logic c, input logic w,
                      input logic [31:0] d, input logic r);
    bit po;
    bit pu;
    @(negedge PCLK);
    bus.CLR   = c;
    bus.WR_EN = w;
    bus.WDATA = d;
    bus.RD_EN = r;
    if (c) begin
      mdl.delete();
    end else begin
      po = r && (mdl.size() != 0);
      pu = w && (mdl.size() != 16);
      if (po) exp_q.push_back(mdl.pop_front());
      if (pu) mdl.push_back(d);
    end
    @(posedge PCLK);
    #1;
    bus.CLR   = 1'b0;
    bus.WR_EN = 1'b0;
    bus.RD_EN = 1'b0;
  endtask

  initial begin
    PRESET    = 1'b1;
    bus.CLR   = 1'b0;
    bus.WR_EN = 1'b0;
    bus.WDATA = '0;
    bus.RD_EN = 1'b0;
    #1;
    chk("rst_count", 32'(bus.COUNT), 0);
    chk("rst_empty", 32'(bus.EMPTY), 1);
    chk("rst_full", 32'(bus.FULL), 0);
    chk("rst_rdata", bus.RDATA, 0);
    @(negedge PCLK);
    PRESET = 1'b0;

    // fill 0x1..0x10
    for (int i = 1; i <= 16; i++)
      step(0, 1, 32'(i), 0);
    chk("fill_full", 32'(bus.FULL), 1);
    chk("fill_count", 32'(bus.COUNT), 16);
    chk("fill_ovf", 32'(bus.OVERFLOW), 0);

    // push 0xDEAD at FULL with a pop: pop wins, push dropped
    step(0, 1, 32'hDEAD, 1);
    chk("ovf_count", 32'(bus.COUNT), 15);
    chk("ovf_flag", 32'(bus.OVERFLOW), 1);
    chk("ovf_full", 32'(bus.FULL), 0);

    for (int i = 0; i < 15; i++)
      step(0, 0, 0, 1);
    chk("drain_empty", 32'(bus.EMPTY), 1);
    chk("drain_count", 32'(bus.COUNT), 0);

    // pop at EMPTY with a push: push lands, pop rejected
    step(0, 1, 32'hA5, 1);
    chk("udf_count", 32'(bus.COUNT), 1);
    chk("udf_flag", 32'(bus.UNDERFLOW), 1);
`ifdef APB_I2C_FIFO_FWFT_EN
    chk("udf_rdata", bus.RDATA, 32'hA5);
`else
    chk("udf_rdata", bus.RDATA, 32'h10);
`endif
    step(0, 0, 0, 1);
    chk("udf_empty", 32'(bus.EMPTY), 1);

    // wrap-around at COUNT=3
    for (int i = 0; i < 3; i++)
      step(0, 1, 32'h100 + 32'(i), 0);
    for (int i = 0; i < 40; i++)
      step(0, 1, 32'h200 + 32'(i), 1);
    chk("wrap_count", 32'(bus.COUNT), 3);
    for (int i = 0; i < 3; i++)
      step(0, 0, 0, 1);

    // flush at COUNT=7 with WR_EN high
    for (int i = 0; i < 7; i++)
      step(0, 1, 32'h300 + 32'(i), 0);
    chk("pre_clr_count", 32'(bus.COUNT), 7);
    chk("pre_clr_ovf", 32'(bus.OVERFLOW), 1);
    step(1, 1, 32'hBAD, 0);
    chk("clr_count", 32'(bus.COUNT), 0);
    chk("clr_ovf", 32'(bus.OVERFLOW), 0);
    chk("clr_udf", 32'(bus.UNDERFLOW), 0);
    chk("clr_empty", 32'(bus.EMPTY), 1);
`ifdef APB_I2C_FIFO_FWFT_EN
    chk("clr_rdata", bus.RDATA, 0);
`else
    chk("clr_rdata", bus.RDATA, 32'h227);
`endif

    step(0, 1, 32'h55, 0);
    chk("p55_count", 32'(bus.COUNT), 1);
`ifdef APB_I2C_FIFO_FWFT_EN
    chk("fwft_rdata", bus.RDATA, 32'h55);
`endif
    step(0, 0, 0, 1);

    // asynchronous reset with COUNT=5
    for (int i = 0; i < 5; i++)
      step(0, 1, 32'h400 + 32'(i), 0);
    step(0, 1, 0, 1);
    step(0, 0, 0, 1);
    chk("mid_count", 32'(bus.COUNT), 4);
    step(0, 1, 32'h77, 0);
    step(0, 0, 0, 0);
    chk("mid_count5", 32'(bus.COUNT), 5);
    #2;
    PRESET = 1'b1;
    #1;
    chk("arst_count", 32'(bus.COUNT), 0);
    chk("arst_empty", 32'(bus.EMPTY), 1);
    chk("arst_full", 32'(bus.FULL), 0);
    chk("arst_rdata", bus.RDATA, 0);
    chk("arst_ovf", 32'(bus.OVERFLOW), 0);
    chk("arst_udf", 32'(bus.UNDERFLOW), 0);
    mdl.delete();
    @(negedge PCLK);
    PRESET = 1'b0;
    step(0, 0, 0, 0);
    chk("post_rst_count", 32'(bus.COUNT), 0);
    chk("sb_drained", 32'(exp_q.size()), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
